// File: rtl/datapath_pkg.sv
// Shared encodings for the RA/RB/RZ adder datapath control sequencer.
package datapath_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T0   = 2'd1,
        S_T1   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_LDA  = 2'd0,
        OP_ADDA = 2'd1,
        OP_ACCB = 2'd2,
        OP_MOVB = 2'd3
    } opcode_t;

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Combinational strobe decode: (state, captured opcode) -> six datapath strobes.
module datapath_ctrl_decode
    import datapath_pkg::*;
(
    input  state_t  state,
    input  opcode_t op,
    output logic    ra_in,
    output logic    rb_in,
    output logic    rz_in,
    output logic    ra_out,
    output logic    rb_out,
    output logic    rz_out,
    output logic    two_step
);

    // Moore decode: strobes depend only on registered state and opcode.
    always_comb begin
        ra_in    = 1'b0;
        rb_in    = 1'b0;
        rz_in    = 1'b0;
        ra_out   = 1'b0;
        rb_out   = 1'b0;
        rz_out   = 1'b0;
        two_step = (op == OP_ADDA) || (op == OP_ACCB);
        case (state)
            S_T0: begin
                case (op)
                    OP_LDA:  ra_in = 1'b1;
                    OP_ADDA: begin ra_out = 1'b1; rz_in = 1'b1; end
                    OP_ACCB: begin rb_out = 1'b1; rz_in = 1'b1; end
                    OP_MOVB: begin ra_out = 1'b1; rb_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T1: begin
                // Second step of both two-step ops writes the sum back to RB.
                if (two_step) begin
                    rz_out = 1'b1;
                    rb_in  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Control sequencer for the RA/RB/RZ adder datapath.
//
// Handshake: start is sampled only while busy is low (IDLE); opcode and count
// are captured on that same edge and ignored afterwards. busy stays high from
// the first step until the DONE cycle inclusive; done pulses for exactly one
// cycle (the DONE state), and the next start is accepted one cycle later.
module datapath_ctrl
    import datapath_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             RAin,
    output logic             RBin,
    output logic             RZin,
    output logic             RAout,
    output logic             RBout,
    output logic             RZout,
    output state_t           state_dbg
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    opcode_t           op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  iter_q;
    logic              two_step;
    logic              last_iter;
    logic              step_end;

    // Equality compare lets count = all-ones finish without the counter wrapping.
    assign last_iter = (iter_q == cnt_q);
    // An iteration ends in T0 for single-step ops and in T1 for two-step ops.
    assign step_end  = ((state == S_T0) && !two_step) || (state == S_T1);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    datapath_ctrl_decode u_decode (
        .state    (state),
        .op       (op_q),
        .ra_in    (RAin),
        .rb_in    (RBin),
        .rz_in    (RZin),
        .ra_out   (RAout),
        .rb_out   (RBout),
        .rz_out   (RZout),
        .two_step (two_step)
    );

    // State register; clear overrides every transition.
    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_T0;
            S_T0: begin
                if (two_step)       state_nxt = S_T1;
                else if (last_iter) state_nxt = S_DONE;
                else                state_nxt = S_T0;
            end
            S_T1:   state_nxt = last_iter ? S_DONE : S_T0;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture at acceptance and iteration counting at each iteration end.
    always_ff @(posedge clock) begin
        if (clear) begin
            op_q   <= OP_LDA;
            cnt_q  <= '0;
            iter_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            op_q   <= opcode_t'(opcode);
            cnt_q  <= (count == '0) ? ONE : count;
            iter_q <= ONE;
        end else if (step_end && !last_iter) begin
            iter_q <= iter_q + ONE;
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl with a behavioural RA/RB/RZ datapath model.
module tb_datapath_ctrl;
    import datapath_pkg::*;

    localparam int CNT_W = 8;

    // Strobe vector order: {RAin, RBin, RZin, RAout, RBout, RZout}
    localparam logic [5:0] SB_NONE   = 6'b000000;
    localparam logic [5:0] SB_LDA    = 6'b100000;
    localparam logic [5:0] SB_ADDA0  = 6'b001100;
    localparam logic [5:0] SB_ACCB0  = 6'b001010;
    localparam logic [5:0] SB_T1     = 6'b010001;
    localparam logic [5:0] SB_MOVB   = 6'b010100;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             clear;
    logic             start;
    logic [1:0]       opcode;
    logic [CNT_W-1:0] count;
    logic             busy, done;
    logic             RAin, RBin, RZin, RAout, RBout, RZout;
    state_t           state_dbg;

    datapath_ctrl #(.CNT_W(CNT_W)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .opcode    (opcode),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .RAin      (RAin),
        .RBin      (RBin),
        .RZin      (RZin),
        .RAout     (RAout),
        .RBout     (RBout),
        .RZout     (RZout),
        .state_dbg (state_dbg)
    );

    logic [5:0] strb;
    assign strb = {RAin, RBin, RZin, RAout, RBout, RZout};

    // ---------------- datapath model ----------------
    logic [7:0] a_val, imm;
    logic [7:0] ra_m, rb_m, rz_m, bus;

    always_comb begin
        bus = 8'h00;
        if (RAout)      bus = ra_m;
        else if (RBout) bus = rb_m;
        else if (RZout) bus = rz_m;
    end

    always @(posedge clock) begin
        if (clear) begin
            ra_m <= 8'h00;
            rb_m <= 8'h00;
            rz_m <= 8'h00;
        end else begin
            if (RAin) ra_m <= imm;
            if (RBin) rb_m <= bus;
            if (RZin) rz_m <= a_val + bus;
        end
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int starts_acc = 0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Invariant monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            check("inv_out_onehot", 32'($countones({RAout, RBout, RZout}) <= 1), 32'd1);
            check("inv_in_out", 32'((RAin & RAout) | (RBin & RBout) | (RZin & RZout)), 32'd0);
            if (!busy || done) check("inv_idle_done_quiet", 32'(strb), 32'd0);
            if (done) done_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] n);
        opcode = op;
        count  = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    function automatic int latency(input logic [1:0] op, input logic [CNT_W-1:0] n);
        int iters;
        iters = (n == '0) ? 1 : int'(n);
        return ((op == OP_ADDA) || (op == OP_ACCB)) ? 2 * iters : iters;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        clear  = 1'b1;
        start  = 1'b0;
        opcode = 2'd0;
        count  = '0;
        a_val  = 8'd0;
        imm    = 8'd0;
        repeat (2) tick();
        clear  = 1'b0;

        // Reset state
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_strb",  32'(strb), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        mon_en = 1'b1;

        // ADDA, count 1
        issue(OP_ADDA, 8'd1);
        check("adda_c1_strb", 32'(strb), 32'(SB_ADDA0));
        check("adda_c1_busy", 32'(busy), 32'd1);
        tick();
        check("adda_c2_strb", 32'(strb), 32'(SB_T1));
        tick();
        check("adda_c3_done", 32'(done), 32'd1);
        check("adda_c3_busy", 32'(busy), 32'd1);
        check("adda_c3_strb", 32'(strb), 32'(SB_NONE));
        tick();
        check("adda_c4_busy", 32'(busy), 32'd0);
        check("adda_c4_done", 32'(done), 32'd0);

        // ACCB count 3 with A=5, RB cleared: RB = 5, 10, 15
        clear = 1'b1;
        tick();
        clear = 1'b0;
        a_val = 8'd5;
        issue(OP_ACCB, 8'd3);
        for (int i = 0; i < 3; i++) begin
            check("accb_t0_strb", 32'(strb), 32'(SB_ACCB0));
            tick();
            check("accb_t1_strb", 32'(strb), 32'(SB_T1));
            tick();
        end
        check("accb_c7_done", 32'(done), 32'd1);
        check("accb_rb", 32'(rb_m), 32'd15);
        tick();
        check("accb_idle", 32'(busy), 32'd0);

        // LDA count 0 (treated as 1), then MOVB count 2
        imm = 8'd9;
        issue(OP_LDA, 8'd0);
        check("lda_c1_strb", 32'(strb), 32'(SB_LDA));
        tick();
        check("lda_c2_done", 32'(done), 32'd1);
        check("lda_ra", 32'(ra_m), 32'd9);
        tick();
        check("lda_idle", 32'(busy), 32'd0);
        issue(OP_MOVB, 8'd2);
        check("movb_c1_strb", 32'(strb), 32'(SB_MOVB));
        tick();
        check("movb_c2_strb", 32'(strb), 32'(SB_MOVB));
        tick();
        check("movb_c3_done", 32'(done), 32'd1);
        check("movb_rb", 32'(rb_m), 32'd9);
        tick();
        check("movb_idle", 32'(busy), 32'd0);

        // start held high, opcode changing mid-operation
        opcode = OP_ADDA;
        count  = 8'd1;
        start  = 1'b1;
        tick();
        opcode = OP_LDA;
        count  = 8'd7;
        check("hold_c1_strb", 32'(strb), 32'(SB_ADDA0));
        tick();
        opcode = OP_MOVB;
        count  = 8'd1;
        check("hold_c2_strb", 32'(strb), 32'(SB_T1));
        tick();
        check("hold_c3_done", 32'(done), 32'd1);
        tick();
        check("hold_c4_busy", 32'(busy), 32'd0);
        check("hold_c4_strb", 32'(strb), 32'(SB_NONE));
        tick();
        start = 1'b0;
        check("hold_c5_strb", 32'(strb), 32'(SB_MOVB));
        tick();
        check("hold_c6_done", 32'(done), 32'd1);
        tick();
        check("hold_c7_busy", 32'(busy), 32'd0);

        // clear during T1 of ADDA count 4
        issue(OP_ADDA, 8'd4);
        tick();
        check("abort_in_t1", 32'(state_dbg), 32'(S_T1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_state", 32'(state_dbg), 32'(S_IDLE));
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_done",  32'(done), 32'd0);
        check("abort_strb",  32'(strb), 32'(SB_NONE));
        issue(OP_ADDA, 8'd2);
        for (int i = 0; i < 2; i++) begin
            check("fresh_t0_strb", 32'(strb), 32'(SB_ADDA0));
            tick();
            check("fresh_t1_strb", 32'(strb), 32'(SB_T1));
            tick();
        end
        check("fresh_done", 32'(done), 32'd1);
        tick();

        // random opcode/count stream, including count extremes
        done_seen  = 0;
        starts_acc = 0;
        for (int k = 0; k < 20; k++) begin
            logic [1:0]       op;
            logic [CNT_W-1:0] n;
            int               lat;
            op = 2'($urandom_range(0, 3));
            if (k == 0)      n = 8'd255;
            else if (k == 1) n = 8'd0;
            else             n = 8'($urandom_range(0, 255));
            lat = latency(op, n);
            issue(op, n);
            starts_acc++;
            for (int c = 1; c <= lat; c++) begin
                check("rnd_busy", 32'(busy & ~done), 32'd1);
                tick();
            end
            check("rnd_done", 32'(done), 32'd1);
            tick();
            check("rnd_idle", 32'(busy), 32'd0);
        end
        check("rnd_done_count", 32'(done_seen), 32'(starts_acc));

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
